// File: rtl/flash_seq_if.sv
// flash_seq_if: host-side request/response bundle of the flash command sequencer.
//
// Handshake: a request transfers on a clock edge where cmd_valid && cmd_ready.
// The sequencer raises cmd_ready only while idle. cmd_op/cmd_addr/cmd_data are
// sampled only on that edge and are ignored at all other times. Completion is a
// single-cycle rsp_valid pulse carrying rsp_data/rsp_err. It has no ready,
// so the host must always accept it.
//
//   cmd_valid  host -> seq  request present
//   cmd_ready  seq -> host  sequencer idle
//   cmd_op     host -> seq  00 read, 01 program, 10 sector erase, 11 chip erase
//   cmd_addr   host -> seq  19-bit byte/sector address
//   cmd_data   host -> seq  program data
//   rsp_valid  seq -> host  one-cycle completion pulse
//   rsp_data   seq -> host  last byte read from flash
//   rsp_err    seq -> host  DQ5 failure or poll timeout
//   busy       seq -> host  from acceptance through rsp_valid
interface flash_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [18:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/flash_seq.sv
// flash_seq: turns one host request (read, byte program, sector erase,
// chip erase) into JEDEC bus cycles on the ROM access controller. Program and
// erase requests finish with DQ7 data polling and DQ5 timeout checking.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   host         flash_seq_if.slave request/response port
//   wr_addr      address-byte strobe (addr[7:0], addr[15:8], {5'b0,addr[18:16]})
//   wr_data      write-cycle strobe, data on wr_buffer
//   rd_data      read-cycle strobe
//   wr_buffer    byte accompanying wr_addr/wr_data
//   autoinc_ena  tied 0
//   rd_buffer    byte returned by the ROM controller
//   dbg_state    current FSM state
module flash_seq #(
  parameter int ACC_WAIT = 8,
  parameter int POLL_MAX = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  flash_seq_if.slave      host,
  output logic            wr_addr,
  output logic            wr_data,
  output logic            rd_data,
  output logic [7:0]      wr_buffer,
  output logic            autoinc_ena,
  input  logic [7:0]      rd_buffer,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR0, ADDR1, ADDR2, STROBE, WAIT, NEXT, POLL, DONE
  } state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_SERASE = 2'b10;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [18:0] addr_q;
  logic [7:0]  data_q;
  logic [2:0]  step;
  logic        reading;    // current bus cycle is a read, not a write
  logic        polling;    // first status read has been issued
  logic        dq5_retry;  // DQ5 was seen; the read in flight is the last one
  logic [15:0] poll_cnt;
  logic [7:0]  wait_cnt;
  logic [7:0]  v_q;        // value of the last read
  logic        err_q;

  logic [18:0] tbl_addr, bus_addr;
  logic [7:0]  tbl_data;
  logic [2:0]  last_step;
  logic        expect_bit, wait_done;
  logic        poll_finish, poll_err;

  // Write table indexed by step. Program uses steps 0..3 and erase uses 0..5.
  always_comb begin
    tbl_addr = 19'h00555;
    tbl_data = 8'hAA;
    case (step)
      3'd0: begin tbl_addr = 19'h00555; tbl_data = 8'hAA; end
      3'd1: begin tbl_addr = 19'h002AA; tbl_data = 8'h55; end
      3'd2: begin tbl_addr = 19'h00555; tbl_data = (op_q == OP_PROG) ? 8'hA0 : 8'h80; end
      3'd3: begin
        if (op_q == OP_PROG) begin tbl_addr = addr_q;   tbl_data = data_q; end
        else                 begin tbl_addr = 19'h00555; tbl_data = 8'hAA; end
      end
      3'd4: begin tbl_addr = 19'h002AA; tbl_data = 8'h55; end
      default: begin
        if (op_q == OP_SERASE) begin tbl_addr = addr_q;   tbl_data = 8'h30; end
        else                   begin tbl_addr = 19'h00555; tbl_data = 8'h10; end
      end
    endcase
  end

  assign last_step  = (op_q == OP_PROG) ? 3'd3 : 3'd5;
  assign expect_bit = (op_q == OP_PROG) ? data_q[7] : 1'b1;
  assign wait_done  = (wait_cnt == 8'(ACC_WAIT - 1));
  // Reads go to the request address, except chip erase which polls address 0.
  assign bus_addr   = reading ? ((op_q == 2'b11) ? 19'h0 : addr_q) : tbl_addr;

  // Poll decision on the latched status byte.
  always_comb begin
    poll_finish = 1'b0;
    poll_err    = 1'b0;
    if (v_q[7] == expect_bit) begin
      poll_finish = 1'b1;
    end else if (dq5_retry) begin
      poll_finish = 1'b1;
      poll_err    = 1'b1;
    end else if (!v_q[5] && poll_cnt == 16'(POLL_MAX)) begin
      poll_finish = 1'b1;
      poll_err    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (host.cmd_valid) state_next = ADDR0;
      ADDR0:  state_next = ADDR1;
      ADDR1:  state_next = ADDR2;
      ADDR2:  state_next = STROBE;
      STROBE: state_next = WAIT;
      WAIT: begin
        if (wait_done) begin
          if (!reading)              state_next = NEXT;
          else if (op_q == OP_READ)  state_next = DONE;
          else                       state_next = POLL;
        end
      end
      NEXT:   state_next = (step == last_step) ? POLL : ADDR0;
      POLL: begin
        if (!polling)         state_next = ADDR0;
        else if (poll_finish) state_next = DONE;
        else                  state_next = ADDR0;
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 2'b00;
      addr_q    <= 19'h0;
      data_q    <= 8'h00;
      step      <= 3'd0;
      reading   <= 1'b0;
      polling   <= 1'b0;
      dq5_retry <= 1'b0;
      poll_cnt  <= 16'h0;
      wait_cnt  <= 8'h00;
      v_q       <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.cmd_valid) begin
            op_q      <= host.cmd_op;
            addr_q    <= host.cmd_addr;
            data_q    <= host.cmd_data;
            step      <= 3'd0;
            reading   <= (host.cmd_op == OP_READ);
            polling   <= 1'b0;
            dq5_retry <= 1'b0;
            poll_cnt  <= 16'h0;
            err_q     <= 1'b0;
          end
        end
        STROBE: wait_cnt <= 8'h00;
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_done && reading) v_q <= rd_buffer;
        end
        NEXT: if (step != last_step) step <= step + 3'd1;
        POLL: begin
          if (!polling) begin
            polling <= 1'b1;
            reading <= 1'b1;
          end else if (poll_finish) begin
            err_q <= poll_err;
          end else if (v_q[5]) begin
            dq5_retry <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_addr   = 1'b0;
    wr_data   = 1'b0;
    rd_data   = 1'b0;
    wr_buffer = 8'h00;
    case (state)
      ADDR0:  begin wr_addr = 1'b1; wr_buffer = bus_addr[7:0]; end
      ADDR1:  begin wr_addr = 1'b1; wr_buffer = bus_addr[15:8]; end
      ADDR2:  begin wr_addr = 1'b1; wr_buffer = {5'b0, bus_addr[18:16]}; end
      STROBE: begin
        if (reading) rd_data = 1'b1;
        else begin wr_data = 1'b1; wr_buffer = tbl_data; end
      end
      default: ;
    endcase
  end

  assign autoinc_ena    = 1'b0;
  assign host.cmd_ready = (state == IDLE);
  assign host.busy      = (state != IDLE);
  assign host.rsp_valid = (state == DONE);
  assign host.rsp_err   = (state == DONE) && err_q;
  assign host.rsp_data  = v_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_flash_seq.sv
module tb_flash_seq;
  localparam int ACC_WAIT = 8;
  localparam int POLL_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_addr, wr_data, rd_data, autoinc_ena;
  logic [7:0] wr_buffer;
  logic [7:0] rd_buffer = 8'h00;
  logic [3:0] dbg_state;

  flash_seq_if host_if ();

  flash_seq #(.ACC_WAIT(ACC_WAIT), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data),
    .wr_buffer(wr_buffer), .autoinc_ena(autoinc_ena),
    .rd_buffer(rd_buffer), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [26:0] exp_wr_q[$];   // {addr, data} of each expected write cycle
  logic [18:0] exp_rd_q[$];   // address of each expected read cycle
  logic [8:0]  exp_rsp_q[$];  // {err, data} of each expected response

  // flash model: first busy_reads reads return busy_val, later ones done_val
  int         busy_reads = 0;
  logic [7:0] busy_val   = 8'h00;
  logic [7:0] done_val   = 8'h00;
  int         rd_seen    = 0;
  int         rsp_cnt    = 0;
  int         acc_cyc    = 0;
  bit         timing_chk = 1'b0;
  logic [7:0] abyte[3];
  int         aidx = 0;
  logic [18:0] cur_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      aidx = 0;
    end else begin
      if (wr_addr || wr_data || rd_data)
        check("one_strobe", 32'(int'(wr_addr) + int'(wr_data) + int'(rd_data)), 1);
      if (wr_addr) begin
        if (aidx < 3) abyte[aidx] = wr_buffer;
        aidx++;
      end
      if (wr_data || rd_data) begin
        check("addr_byte_count", aidx, 3);
        check("addr_hi_pad", {27'b0, abyte[2][7:3]}, 0);
        cur_addr = {abyte[2][2:0], abyte[1], abyte[0]};
        aidx = 0;
      end
      if (wr_data) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", {5'b0, cur_addr, wr_buffer}, 0);
        else check("wr_cycle", {5'b0, cur_addr, wr_buffer}, {5'b0, exp_wr_q.pop_front()});
      end
      if (rd_data) begin
        if (timing_chk && rd_seen == 0) check("rd_latency", cyc - acc_cyc, 4);
        if (exp_rd_q.size() == 0) check("rd_unexpected", {13'b0, cur_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {13'b0, cur_addr}, {13'b0, exp_rd_q.pop_front()});
        rd_buffer = (rd_seen < busy_reads) ? busy_val : done_val;
        rd_seen++;
      end
      if (host_if.rsp_valid) begin
        check("busy_at_rsp", host_if.busy, 1);
        if (timing_chk) check("rsp_latency", cyc - acc_cyc, 13);
        if (exp_rsp_q.size() == 0)
          check("rsp_unexpected", {host_if.rsp_err, host_if.rsp_data}, 32'hFFFF_FFFF);
        else
          check("rsp", {host_if.rsp_err, host_if.rsp_data}, {23'b0, exp_rsp_q.pop_front()});
        rsp_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_wr(input logic [18:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [18:0] addr, input logic [7:0] data);
    int t;
    @(negedge clk);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = addr;
    host_if.cmd_data  = data;
    t = 0;
    while (!host_if.cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("cmd_ready_seen", host_if.cmd_ready, 1);
    acc_cyc = cyc;
    rd_seen = 0;
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'($urandom_range(0, 3));
    host_if.cmd_addr  = 19'($urandom_range(0, 19'h7FFFF));
    check("busy_after_accept", host_if.busy, 1);
    check("ready_low_busy", host_if.cmd_ready, 0);
  endtask

  task automatic wait_rsp(input int exp_reads);
    int start;
    int t;
    start = rsp_cnt;
    t = 0;
    while (rsp_cnt == start && t < 1000) begin @(negedge clk); t++; end
    if (rsp_cnt == start) check("rsp_timeout", 0, 1);
    @(posedge clk); #1;
    check("ready_after_rsp", host_if.cmd_ready, 1);
    check("idle_after_rsp", host_if.busy, 0);
    check("reads_issued", rd_seen, exp_reads);
    check("wr_left", exp_wr_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("rsp_left", exp_rsp_q.size(), 0);
  endtask

  task automatic do_read(input logic [18:0] addr, input logic [7:0] val);
    busy_reads = 0;
    done_val   = val;
    timing_chk = 1'b1;
    exp_rd_q.push_back(addr);
    exp_rsp_q.push_back({1'b0, val});
    send_cmd(2'b00, addr, 8'h00);
    wait_rsp(1);
    timing_chk = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_addr  = 19'h0;
    host_if.cmd_data  = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_buffer", wr_buffer, 0);
    check("rst_autoinc", autoinc_ena, 0);
    check("rst_rsp_valid", host_if.rsp_valid, 0);
    check("rst_rsp_data", host_if.rsp_data, 0);
    check("rst_rsp_err", host_if.rsp_err, 0);
    check("rst_busy", host_if.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", host_if.cmd_ready, 1);

    // plain read
    do_read(19'h12345, 8'h5A);

    // program, DQ7 inverted for 3 polls
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55);
    push_wr(19'h00555, 8'hA0); push_wr(19'h7FFFF, 8'h80);
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(19'h7FFFF);
    exp_rsp_q.push_back({1'b0, 8'h80});
    busy_reads = 3; busy_val = 8'h00; done_val = 8'h80;
    send_cmd(2'b01, 19'h7FFFF, 8'h80);
    wait_rsp(4);

    // program with DQ5 set and DQ7 never matching
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55);
    push_wr(19'h00555, 8'hA0); push_wr(19'h01234, 8'h00);
    for (int i = 0; i < 2; i++) exp_rd_q.push_back(19'h01234);
    exp_rsp_q.push_back({1'b1, 8'hA0});
    busy_reads = 100; busy_val = 8'hA0; done_val = 8'hA0;
    send_cmd(2'b01, 19'h01234, 8'h00);
    wait_rsp(2);

    // chip erase, polls at address 0
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55); push_wr(19'h00555, 8'h80);
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55); push_wr(19'h00555, 8'h10);
    for (int i = 0; i < 3; i++) exp_rd_q.push_back(19'h00000);
    exp_rsp_q.push_back({1'b0, 8'hFF});
    busy_reads = 2; busy_val = 8'h00; done_val = 8'hFF;
    send_cmd(2'b11, 19'h55555, 8'h00);
    wait_rsp(3);

    // sector erase that never completes: POLL_MAX+1 status reads
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55); push_wr(19'h00555, 8'h80);
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55); push_wr(19'h3A000, 8'h30);
    for (int i = 0; i < POLL_MAX + 1; i++) exp_rd_q.push_back(19'h3A000);
    exp_rsp_q.push_back({1'b1, 8'h00});
    busy_reads = 100; busy_val = 8'h00; done_val = 8'h00;
    send_cmd(2'b10, 19'h3A000, 8'h00);
    wait_rsp(POLL_MAX + 1);

    // reset during ADDR1 of write 3
    push_wr(19'h00555, 8'hAA); push_wr(19'h002AA, 8'h55);
    push_wr(19'h00555, 8'hA0); push_wr(19'h10000, 8'h3C);
    busy_reads = 0; done_val = 8'h3C;
    send_cmd(2'b01, 19'h10000, 8'h3C);
    t = 0;
    while (cyc != acc_cyc + 28 && t < 100) begin @(negedge clk); t++; end
    check("reached_write3_addr1", wr_addr, 1);
    check("write3_addr1_byte", wr_buffer, 8'h05);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_busy", host_if.busy, 0);
    check("mid_rst_ready", host_if.cmd_ready, 1);
    check("mid_rst_wr_seen", exp_wr_q.size(), 2);
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(19'h00ABC, 8'hC3);

    // random reads
    for (int i = 0; i < 4; i++)
      do_read(19'($urandom_range(0, 19'h7FFFF)), 8'($urandom_range(0, 255)));

    check("final_wr_q", exp_wr_q.size(), 0);
    check("final_rd_q", exp_rd_q.size(), 0);
    check("final_rsp_q", exp_rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
